// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch stage, the load/store unit, the arbiter and the memory.
// The arbiter connects through the slave modport; the requesters and memory use master.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic                d_req;
   logic                d_we;
   logic [ADDR_W-1:0]   d_addr;
   logic [DATA_W-1:0]   d_wdata;
   logic [DATA_W/8-1:0] d_wstrb;
   logic                d_gnt;
   logic                d_rvalid;
   logic [DATA_W-1:0]   d_rdata;

   logic                mem_req;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W/8-1:0] mem_wstrb;
   logic                mem_ack;
   logic [DATA_W-1:0]   mem_rdata;

   modport slave (
      input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data side has priority, fetch is forced after STARVE_MAX
// back-to-back data grants, and a taken jump kills the in-flight fetch response.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic           clk,
   input  logic           rst,
   mem_port_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, IF_WAIT, D_WAIT} state_t;

   state_t           state;
   logic [CNT_W-1:0] starve_cnt;
   logic             kill;
   logic             if_eligible;
   logic             pick_fetch;

   // A flush in the arbitration cycle makes the pending fetch address stale.
   assign if_eligible = bus.if_req & ~bus.if_flush;
   assign pick_fetch  = if_eligible & (~bus.d_req | (starve_cnt == CNT_MAX));

   // NOTE: all state and outputs use non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         starve_cnt    <= '0;
         kill          <= 1'b0;
         bus.if_gnt    <= 1'b0;
         bus.if_rvalid <= 1'b0;
         bus.if_rdata  <= {DATA_W{1'b0}};
         bus.d_gnt     <= 1'b0;
         bus.d_rvalid  <= 1'b0;
         bus.d_rdata   <= {DATA_W{1'b0}};
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= {ADDR_W{1'b0}};
         bus.mem_wdata <= {DATA_W{1'b0}};
         bus.mem_wstrb <= {(DATA_W/8){1'b0}};
      end else begin
         // NOTE: pulse outputs default low every cycle, so any set below lasts one clock.
         bus.if_gnt    <= 1'b0;
         bus.d_gnt     <= 1'b0;
         bus.if_rvalid <= 1'b0;
         bus.d_rvalid  <= 1'b0;

         if (!bus.if_req) starve_cnt <= '0;

         case (state)
            IDLE: begin
               kill <= 1'b0;
               if (pick_fetch) begin
                  state         <= IF_WAIT;
                  bus.if_gnt    <= 1'b1;
                  bus.mem_req   <= 1'b1;
                  bus.mem_we    <= 1'b0;
                  bus.mem_addr  <= bus.if_addr;
                  bus.mem_wdata <= {DATA_W{1'b0}};
                  bus.mem_wstrb <= {(DATA_W/8){1'b0}};
                  starve_cnt    <= '0;
               end else if (bus.d_req) begin
                  state         <= D_WAIT;
                  bus.d_gnt     <= 1'b1;
                  bus.mem_req   <= 1'b1;
                  bus.mem_we    <= bus.d_we;
                  bus.mem_addr  <= bus.d_addr;
                  bus.mem_wdata <= bus.d_wdata;
                  bus.mem_wstrb <= bus.d_wstrb;
                  if (bus.if_req && starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 1'b1;
               end
            end

            IF_WAIT: begin
               if (bus.if_flush) kill <= 1'b1;
               if (bus.mem_ack) begin
                  state       <= IDLE;
                  bus.mem_req <= 1'b0;
                  // A killed fetch still finishes on memory; only the response is dropped.
                  if (!kill && !bus.if_flush) begin
                     bus.if_rvalid <= 1'b1;
                     bus.if_rdata  <= bus.mem_rdata;
                  end
               end
            end

            D_WAIT: begin
               if (bus.mem_ack) begin
                  state        <= IDLE;
                  bus.mem_req  <= 1'b0;
                  bus.d_rvalid <= 1'b1;
                  bus.d_rdata  <= bus.mem_rdata;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: variable-latency memory model, response scoreboard,
// table-driven single transactions and hand-written priority/flush/reset sequences.
module tb_mem_port_arbiter;
   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 4;

   typedef struct {
      bit          is_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          k;
      logic [31:0] rdata;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      bit          chk;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          total = 0;
   int          bad   = 0;
   exp_t        exp_if[$];
   exp_t        exp_d[$];
   logic [31:0] gbits;
   int          gcount;
   logic [31:0] last_if = '0;
   logic [31:0] last_d  = '0;
   bit          last_d_known = 1'b1;
   bit          hold_if = 1'b0;
   bit          hold_d  = 1'b0;
   logic        prev_req = 1'b0;
   logic        prev_ack = 1'b0;
   logic [68:0] prev_bundle = '0;
   int          lat_k = 0;
   vec_t        vecs[7];

   function automatic logic [31:0] defval(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, 16'hC0DE};
   endfunction

   // Memory model: acks k cycles after mem_req first appears, tolerates withdrawal.
   logic [31:0] mem [logic [31:0]];
   initial begin : mem_model
      bit          busy;
      int          cnt;
      logic [31:0] word;
      busy = 1'b0;
      cnt  = 0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      mem[32'h40]   = 32'h0000_0013;
      mem[32'h300]  = 32'h1122_3344;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_ack = 1'b0;
         if (!bus.mem_req) begin
            busy = 1'b0;
         end else begin
            if (!busy) begin
               busy = 1'b1;
               cnt  = lat_k;
            end
            if (cnt == 0) begin
               busy        = 1'b0;
               bus.mem_ack = 1'b1;
               word = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : defval(bus.mem_addr);
               if (bus.mem_we) begin
                  for (int b = 0; b < 4; b++)
                     if (bus.mem_wstrb[b]) word[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
                  mem[bus.mem_addr] = word;
                  bus.mem_rdata = 32'h0;
               end else begin
                  bus.mem_rdata = word;
               end
            end else begin
               cnt--;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Advance one cycle, sample away from the edge, score responses, emulate requesters.
   task automatic tick();
      exp_t        e;
      logic [68:0] cur;
      @(posedge clk);
      #2;
      if (bus.if_gnt || bus.d_gnt) begin
         gbits = {gbits[30:0], bus.if_gnt};
         gcount++;
      end
      if (bus.if_rvalid) begin
         if (exp_if.size() == 0) begin
            check("if_rvalid_unexpected", 96'(bus.if_rvalid), 96'(0));
         end else begin
            e = exp_if.pop_front();
            check("if_rdata", 96'(bus.if_rdata), 96'(e.data));
            last_if = e.data;
         end
      end
      if (bus.d_rvalid) begin
         if (exp_d.size() == 0) begin
            check("d_rvalid_unexpected", 96'(bus.d_rvalid), 96'(0));
         end else begin
            e = exp_d.pop_front();
            if (e.chk) begin
               check("d_rdata", 96'(bus.d_rdata), 96'(e.data));
               last_d = e.data;
            end
            last_d_known = e.chk;
         end
      end
      cur = {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb};
      if (rst && prev_req && !prev_ack) begin
         check("mem_req_held", 96'(bus.mem_req), 96'(1));
         check("mem_fields_stable", 96'(cur), 96'(prev_bundle));
      end
      prev_req    = bus.mem_req;
      prev_ack    = bus.mem_ack;
      prev_bundle = cur;
      if (bus.if_gnt && !hold_if) bus.if_req = 1'b0;
      if (bus.d_gnt && !hold_d) bus.d_req = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (n < budget && (exp_if.size() != 0 || exp_d.size() != 0 || bus.mem_req ||
                            bus.if_req || bus.d_req)) begin
         tick();
         n++;
      end
      check({tag, "_drain"}, 96'({bus.if_req, bus.d_req, bus.mem_req, exp_if.size(), exp_d.size()}),
            96'(0));
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      int n;
      bit seen;
      bit other;
      lat_k = v.k;
      if (v.is_d) begin
         bus.d_req   = 1'b1;
         bus.d_we    = v.we;
         bus.d_addr  = v.addr;
         bus.d_wdata = v.wdata;
         bus.d_wstrb = v.wstrb;
         exp_d.push_back('{v.rdata, !v.we});
      end else begin
         bus.if_req  = 1'b1;
         bus.if_addr = v.addr;
         exp_if.push_back('{v.rdata, 1'b1});
      end
      tick();
      check($sformatf("v%0d_gnt", idx), 96'({bus.if_gnt, bus.d_gnt, bus.mem_req}),
            96'({!v.is_d, v.is_d, 1'b1}));
      check($sformatf("v%0d_mem_addr", idx), 96'({bus.mem_we, bus.mem_addr}), 96'({v.we, v.addr}));
      if (v.we)
         check($sformatf("v%0d_mem_wr", idx), 96'({bus.mem_wdata, bus.mem_wstrb}),
               96'({v.wdata, v.wstrb}));
      n = 0;
      seen = 1'b0;
      other = 1'b0;
      while (!seen && n < 20) begin
         tick();
         n++;
         seen  = v.is_d ? bus.d_rvalid : bus.if_rvalid;
         other = other | (v.is_d ? (bus.if_gnt | bus.if_rvalid) : (bus.d_gnt | bus.d_rvalid));
      end
      check($sformatf("v%0d_rvalid_latency", idx), 96'(n), 96'(v.k + 1));
      check($sformatf("v%0d_other_port_quiet", idx), 96'(other), 96'(0));
      if (v.is_d)
         check($sformatf("v%0d_if_rdata_hold", idx), 96'(bus.if_rdata), 96'(last_if));
      else if (last_d_known)
         check($sformatf("v%0d_d_rdata_hold", idx), 96'(bus.d_rdata), 96'(last_d));
      tick();
   endtask

   initial begin : main
      int n;
      int rv;
      vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,         4'h0,    2, 32'h0000_0013};
      vecs[1] = '{1'b1, 1'b0, 32'h200, 32'h0,         4'h0,    1, defval(32'h200)};
      vecs[2] = '{1'b1, 1'b1, 32'h300, 32'hDEAD_BEEF, 4'b0011, 3, 32'h0};
      vecs[3] = '{1'b1, 1'b0, 32'h300, 32'h0,         4'h0,    0, 32'h1122_BEEF};
      vecs[4] = '{1'b0, 1'b0, 32'h44,  32'h0,         4'h0,    0, defval(32'h44)};
      vecs[5] = '{1'b1, 1'b1, 32'h304, 32'hCAFE_F00D, 4'b1000, 1, 32'h0};
      vecs[6] = '{1'b1, 1'b0, 32'h304, 32'h0,         4'h0,    2, 32'hCA5E_C0DE};

      bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
      gbits = '0;
      gcount = 0;
      rst = 1'b1;
      #3 rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("reset_ctrl", 96'({bus.if_gnt, bus.if_rvalid, bus.d_gnt, bus.d_rvalid, bus.mem_req,
                               bus.mem_we, bus.mem_wstrb}), 96'(0));
      check("reset_data", 96'({bus.if_rdata, bus.d_rdata, bus.mem_addr}), 96'(0));
      check("reset_wdata", 96'(bus.mem_wdata), 96'(0));
      rst = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) apply_vec(vecs[i], i);

      // Simultaneous requests: data first, fetch after the data response.
      lat_k = 1;
      gcount = 0;
      bus.if_req = 1'b1; bus.if_addr = 32'h80;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
      exp_d.push_back('{defval(32'h200), 1'b1});
      exp_if.push_back('{defval(32'h80), 1'b1});
      tick();
      check("both_req_d_first", 96'({bus.d_gnt, bus.if_gnt, bus.mem_we, bus.mem_addr}),
            96'({1'b1, 1'b0, 1'b0, 32'h200}));
      wait_idle("both_req", 40);
      check("both_req_order", 96'({gcount, gbits[1:0]}), 96'({32'd2, 2'b01}));

      // Starvation guard with both requesters continuously asserting.
      lat_k = 0;
      gcount = 0;
      gbits = '0;
      hold_if = 1'b1;
      hold_d = 1'b1;
      for (int i = 0; i < 8; i++) exp_d.push_back('{defval(32'h500), 1'b1});
      for (int i = 0; i < 2; i++) exp_if.push_back('{defval(32'h80), 1'b1});
      bus.if_req = 1'b1; bus.if_addr = 32'h80;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500;
      n = 0;
      while (gcount < 10 && n < 100) begin
         tick();
         n++;
      end
      hold_if = 1'b0;
      hold_d = 1'b0;
      bus.if_req = 1'b0;
      bus.d_req = 1'b0;
      wait_idle("starve", 20);
      check("starve_order", 96'({gcount, gbits[9:0]}), 96'({32'd10, 10'b0000100001}));

      // Flush: arbitration-cycle flush drops the fetch; flush in IF_WAIT kills its response.
      gcount = 0;
      gbits = '0;
      lat_k = 3;
      bus.if_req = 1'b1; bus.if_addr = 32'h44; bus.if_flush = 1'b1;
      tick();
      check("flush_arb_no_gnt", 96'({bus.if_gnt, bus.mem_req}), 96'(0));
      bus.if_flush = 1'b0;
      tick();
      check("fetch44_gnt", 96'({bus.if_gnt, bus.mem_addr}), 96'({1'b1, 32'h44}));
      tick();
      bus.if_flush = 1'b1;
      tick();
      bus.if_flush = 1'b0;
      lat_k = 1;
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      exp_if.push_back('{defval(32'h100), 1'b1});
      wait_idle("flush", 40);
      check("flush_grants", 96'({gcount, gbits[1:0]}), 96'({32'd2, 2'b11}));

      // Flush coinciding with the gnt cycle and the ack edge (k=0).
      lat_k = 0;
      bus.if_req = 1'b1; bus.if_addr = 32'h48;
      tick();
      bus.if_flush = 1'b1;
      tick();
      bus.if_flush = 1'b0;
      check("flush_ack_no_rvalid", 96'(bus.if_rvalid), 96'(0));
      wait_idle("flush_ack", 20);
      check("flush_ack_rdata_hold", 96'(bus.if_rdata), 96'(last_if));

      // Asynchronous reset in D_WAIT abandons the load.
      lat_k = 5;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h600;
      tick();
      check("rst_case_gnt", 96'(bus.d_gnt), 96'(1));
      tick();
      tick();
      #1 rst = 1'b0;
      #1;
      check("rst_async_ctrl", 96'({bus.d_gnt, bus.d_rvalid, bus.if_gnt, bus.if_rvalid, bus.mem_req,
                                   bus.mem_we, bus.mem_wstrb}), 96'(0));
      check("rst_async_data", 96'({bus.mem_addr, bus.if_rdata, bus.d_rdata}), 96'(0));
      tick();
      rst = 1'b1;
      rv = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         rv += int'(bus.d_rvalid);
      end
      check("rst_no_rvalid", 96'(rv), 96'(0));
      last_d = '0;
      last_if = '0;
      last_d_known = 1'b1;
      apply_vec(vecs[4], 7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
